// File: rtl/jtag_pkg.sv
// IEEE 1149.1 TAP state encoding shared by the controller, instruction register and tdo mux.
// Latency: n/a (types only).
// Backpressure: n/a.
package jtag_pkg;

   // Codes are the standard 1149.1 assignment. Downstream blocks decode them directly,
   // so the values must not be renumbered.
   typedef enum logic [3:0] {
      TLR    = 4'hF,
      RTI    = 4'hC,
      SEL_DR = 4'h7,
      CAP_DR = 4'h6,
      SH_DR  = 4'h2,
      EX1_DR = 4'h1,
      PAU_DR = 4'h3,
      EX2_DR = 4'h0,
      UPD_DR = 4'h5,
      SEL_IR = 4'h4,
      CAP_IR = 4'hE,
      SH_IR  = 4'hA,
      EX1_IR = 4'h9,
      PAU_IR = 4'hB,
      EX2_IR = 4'h8,
      UPD_IR = 4'hD
   } tap_state_t;

endpackage

// File: rtl/tap_clock_gate.sv
// Gated test clock: enable registered on falling tck, ANDed with tck.
// Latency: enable takes effect on the rising tck after the falling edge that samples it.
// Backpressure: none; reset clears the enable at once, so the gated clock drops immediately.
module tap_clock_gate (
   input  logic clk,
   input  logic rst,
   input  logic en_next,
   output logic gated_clk
);

   logic en;

   // Enable changes only while clk is low, so clk & en cannot glitch.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) en <= 1'b0;
      else     en <= en_next;
   end

   assign gated_clk = clk & en;

endmodule

// File: rtl/tap_controller.sv
// 1149.1 TAP controller: 16-state TMS FSM, decoded strobes and gated DR/IR clocks.
// Latency: state moves on rising tck; update/tdo_en/tl_reset follow on the next falling tck.
// Backpressure: none; tms is consumed on every rising tck, trst forces TEST_LOGIC_RESET asynchronously.
module tap_controller
   import jtag_pkg::*;
(
   input  logic       tck,
   input  logic       trst,
   input  logic       tms,
   output logic [3:0] state,
   output logic       captureDR,
   output logic       shiftDR,
   output logic       clockDR,
   output logic       updateDR,
   output logic       captureIR,
   output logic       shiftIR,
   output logic       clockIR,
   output logic       updateIR,
   output logic       select,
   output logic       tdo_en,
   output logic       tl_reset
);

   tap_state_t cur_state;
   tap_state_t nxt_state;

   // State register: advances on rising tck, trst forces TLR regardless of tck.
   always_ff @(posedge tck or posedge trst) begin
      if (trst) cur_state <= TLR;
      else      cur_state <= nxt_state;
   end

   // Next-state table; the IR column mirrors the DR column.
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         TLR:     nxt_state = tms ? TLR    : RTI;
         RTI:     nxt_state = tms ? SEL_DR : RTI;
         SEL_DR:  nxt_state = tms ? SEL_IR : CAP_DR;
         CAP_DR:  nxt_state = tms ? EX1_DR : SH_DR;
         SH_DR:   nxt_state = tms ? EX1_DR : SH_DR;
         EX1_DR:  nxt_state = tms ? UPD_DR : PAU_DR;
         PAU_DR:  nxt_state = tms ? EX2_DR : PAU_DR;
         EX2_DR:  nxt_state = tms ? UPD_DR : SH_DR;
         UPD_DR:  nxt_state = tms ? SEL_DR : RTI;
         SEL_IR:  nxt_state = tms ? TLR    : CAP_IR;
         CAP_IR:  nxt_state = tms ? EX1_IR : SH_IR;
         SH_IR:   nxt_state = tms ? EX1_IR : SH_IR;
         EX1_IR:  nxt_state = tms ? UPD_IR : PAU_IR;
         PAU_IR:  nxt_state = tms ? EX2_IR : PAU_IR;
         EX2_IR:  nxt_state = tms ? UPD_IR : SH_IR;
         UPD_IR:  nxt_state = tms ? SEL_DR : RTI;
         default: nxt_state = TLR;
      endcase
   end

   // Pure state decodes: stable across the rising tck that leaves the state,
   // so registers clocked by clockDR/clockIR see the value of the state they are leaving.
   assign state     = cur_state;
   assign captureDR = (cur_state == CAP_DR);
   assign shiftDR   = (cur_state == SH_DR);
   assign captureIR = (cur_state == CAP_IR);
   assign shiftIR   = (cur_state == SH_IR);
   assign select    = cur_state inside {SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR};

   logic en_dr_next;
   logic en_ir_next;

   assign en_dr_next = cur_state inside {CAP_DR, SH_DR};
   assign en_ir_next = cur_state inside {CAP_IR, SH_IR};

   tap_clock_gate u_dr_gate (
      .clk       (tck),
      .rst       (trst),
      .en_next   (en_dr_next),
      .gated_clk (clockDR)
   );

   tap_clock_gate u_ir_gate (
      .clk       (tck),
      .rst       (trst),
      .en_next   (en_ir_next),
      .gated_clk (clockIR)
   );

   // Falling-edge strobes: one full tck period wide, centred on the rising edge that leaves the state.
   always_ff @(negedge tck or posedge trst) begin
      if (trst) begin
         updateDR <= 1'b0;
         updateIR <= 1'b0;
         tdo_en   <= 1'b0;
         tl_reset <= 1'b1;
      end else begin
         updateDR <= (cur_state == UPD_DR);
         updateIR <= (cur_state == UPD_IR);
         tdo_en   <= cur_state inside {SH_DR, SH_IR};
         tl_reset <= (cur_state == TLR);
      end
   end

endmodule
